// File: rtl/seven_seg_if.sv
// Bus between the I/O register decode and the seven-segment scanner:
// digit writes and enable in, segment/anode drive and frame strobe out.
interface seven_seg_if #(
  parameter int DIGITS = 4
) ();
  logic              en;
  logic              wr_en;
  logic [2:0]        wr_addr;
  logic [3:0]        wr_data;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;
  logic              frame;

  modport master (output en, wr_en, wr_addr, wr_data, input seg, an, frame);
  modport slave  (input en, wr_en, wr_addr, wr_data, output seg, an, frame);
endinterface

// File: rtl/seven_seg_scan.sv
// Multiplexed common-anode hex display scanner sharing one decoder across all digits.
// Optional leading-zero blanking is compiled in when SEVEN_SEG_LZB_EN is defined.
module seven_seg_scan #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int BLANK  = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  seven_seg_if.slave bus
);
  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0]     CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0]     CNT_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0]     BLANK_LAST = CW'(BLANK - 1);
  localparam logic [IW-1:0]     IDX_ZERO   = {IW{1'b0}};
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF     = {DIGITS{1'b1}};
  localparam logic [DIGITS-1:0] AN_ONE     = {{(DIGITS-1){1'b0}}, 1'b1};
  localparam logic [6:0]        SEG_OFF    = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t            state_r;
  logic [CW-1:0]     cnt_r;
  logic [IW-1:0]     idx_r;
  logic [3:0]        cur_r;
  logic [3:0]        d_r   [DIGITS];
  logic [3:0]        eff_s [DIGITS];
  logic [3:0]        lat_s;
  logic [6:0]        seg_r;
  logic [DIGITS-1:0] an_r;
  logic              frame_r;
`ifdef SEVEN_SEG_LZB_EN
  logic              lzb_s;
  logic              cur_blank_r;
`endif

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // Digit values as they will be after this edge, so a write on the latch edge is seen.
  always_comb begin
    lat_s = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      eff_s[i] = (bus.wr_en && bus.wr_addr == 3'(i)) ? bus.wr_data : d_r[i];
      lat_s    = (idx_r == IW'(i)) ? eff_s[i] : lat_s;
    end
`ifdef SEVEN_SEG_LZB_EN
    lzb_s = (idx_r != IDX_ZERO);
    for (int j = 0; j < DIGITS; j++) begin
      lzb_s = (IW'(j) >= idx_r && eff_s[j] != 4'h0) ? 1'b0 : lzb_s;
    end
`endif
  end

  // Digit register file; out-of-range addresses match no entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DIGITS; i++) d_r[i] <= 4'h0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (bus.wr_en && bus.wr_addr == 3'(i)) d_r[i] <= bus.wr_data;
      end
    end
  end

  // Scan FSM with registered pin drive; pins follow the state of the previous cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= IDX_ZERO;
      cur_r   <= 4'h0;
      seg_r   <= SEG_OFF;
      an_r    <= AN_OFF;
      frame_r <= 1'b0;
`ifdef SEVEN_SEG_LZB_EN
      cur_blank_r <= 1'b0;
`endif
    end else if (!bus.en) begin
      // Disable wins in every state and blanks the pins on the very next cycle.
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= IDX_ZERO;
      seg_r   <= SEG_OFF;
      an_r    <= AN_OFF;
      frame_r <= 1'b0;
    end else begin
      seg_r   <= SEG_OFF;
      an_r    <= AN_OFF;
      frame_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_BLANK;
          cnt_r   <= CNT_ZERO;
          idx_r   <= IDX_ZERO;
        end
        ST_BLANK: begin
          if (cnt_r == BLANK_LAST) begin
            cur_r   <= lat_s;
            state_r <= ST_SHOW;
`ifdef SEVEN_SEG_LZB_EN
            cur_blank_r <= lzb_s;
`endif
          end
          cnt_r <= cnt_r + 1'b1;
        end
        ST_SHOW: begin
`ifdef SEVEN_SEG_LZB_EN
          if (!cur_blank_r) begin
            seg_r <= hex7(cur_r);
            an_r  <= ~(AN_ONE << idx_r);
          end
`else
          seg_r <= hex7(cur_r);
          an_r  <= ~(AN_ONE << idx_r);
`endif
          if (cnt_r == CNT_LAST) begin
            cnt_r   <= CNT_ZERO;
            idx_r   <= (idx_r == IDX_LAST) ? IDX_ZERO : idx_r + 1'b1;
            state_r <= ST_BLANK;
            frame_r <= (idx_r == IDX_LAST);
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
          idx_r   <= IDX_ZERO;
        end
      endcase
    end
  end

  assign bus.seg   = seg_r;
  assign bus.an    = an_r;
  assign bus.frame = frame_r;
endmodule
